mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Sits between the processor's I-cache/D-cache miss paths and the single off-chip memory port (proc2mem_*/mem2proc_*) driven into the memory model.
- Arbitrates one request per cycle onto the shared bus.
- Records which requester owns each outstanding load tag, and routes returned data and tags back to that requester.
- D-cache has default priority; a starvation counter guarantees I-cache forward progress.

Parameters:
- XLEN, 32, address width.
- STARVE_LIMIT, 4, consecutive denied I-cache request cycles before the I-cache is forced to win.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low (asserted at 0); clears all state immediately.
- ic2arb_command  in  2  I-cache command: 0 NONE, 1 LOAD (STORE is never issued by the I-cache).
- ic2arb_addr  in  XLEN  I-cache line address.
- arb2ic_response  out  4  accept tag for the I-cache; 0 = not accepted, retry.
- arb2ic_data  out  64  returned line for the I-cache.
- arb2ic_tag  out  4  return tag for the I-cache; 0 = no return this cycle.
- dc2arb_command  in  2  D-cache command: 0 NONE, 1 LOAD, 2 STORE.
- dc2arb_addr  in  XLEN  D-cache address.
- dc2arb_data  in  64  store data.
- dc2arb_size  in  2  access size (BYTE/HALF/WORD/DOUBLE encoding).
- arb2dc_response  out  4  accept tag for the D-cache; 0 = retry.
- arb2dc_data  out  64  returned data for the D-cache.
- arb2dc_tag  out  4  return tag for the D-cache.
- proc2mem_command  out  2  bus command.
- proc2mem_addr  out  XLEN  bus address.
- proc2mem_data  out  64  bus store data.
- proc2mem_size  out  2  bus size.
- mem2proc_response  in  4  memory accept tag; 0 = busy.
- mem2proc_data  in  64  returned data.
- mem2proc_tag  in  4  returned tag; 0 = none.
- outstanding_cnt  out  5  number of valid load-tag entries (0..15).
- tag_error  out  1  sticky: a return arrived for an unowned tag.

Behaviour:
Grant (combinational, same cycle):
- If only one requester is non-NONE, it is granted.
- If both are non-NONE, the D-cache is granted, unless starve_cnt == STARVE_LIMIT, in which case the I-cache is granted.
- The granted requester's command, addr, data and size drive proc2mem_*.
- The I-cache path drives data 0 and size DOUBLE.
- With no requester, proc2mem_command = NONE and addr/data/size = 0.

Accept routing (combinational):
- mem2proc_response is copied to the granted requester's response output.
- The non-granted requester's response is 0.
- A requester seeing response 0 holds its request and retries next cycle; the arbiter keeps no request buffer.
- A STORE accepted with a nonzero response allocates no tag entry; no data return is expected.

Tag table (registered):
- 15 entries for tags 1..15; each entry holds valid and owner (0 = IC, 1 = DC).
- On posedge, an accepted LOAD (response != 0) sets entry[response] = {valid 1, owner}.

Return routing (combinational lookup on the current table):
- mem2proc_tag != 0 and entry valid: data and tag go to the owner's outputs; the other requester's tag is 0 and its data is 0. The entry is cleared on the posedge.
- mem2proc_tag != 0 and entry invalid: both tag outputs are 0, and tag_error is set on the posedge (sticky until reset).
- If the same tag is returned and re-allocated in one cycle, the allocation wins: the entry stays valid with the new owner.
- Allocating a tag that is already valid overwrites the entry and sets tag_error.

Counters:
- outstanding_cnt = number of valid entries, registered. It updates on the same edge as the table: +1 alloc, -1 clear, net 0 when both happen.
- starve_cnt is internal, width $clog2(STARVE_LIMIT+1).
  - Reset to 0 when the I-cache is accepted or ic2arb_command == NONE.
  - Otherwise incremented while the I-cache requests and is denied, saturating at STARVE_LIMIT.
  - It stays at the limit until the I-cache is accepted. A force-grant rejected by memory keeps the I-cache forced next cycle.

Reset (reset = 0, asynchronous):
- Table cleared, outstanding_cnt = 0, starve_cnt = 0, tag_error = 0.
- While reset is asserted, all outputs are forced to 0: proc2mem_command NONE, all responses, tags and data 0.
- Loads in flight when reset asserts are forgotten. Returns arriving after release hit invalid entries and set tag_error; this is the required behaviour.

Test Plan:
- Single load: DC LOAD 0x100, memory responds 3, later returns tag 3 with data 0xDEADBEEF_CAFEF00D. Required: arb2dc_response = 3 that cycle; on the return cycle arb2dc_tag = 3 and arb2dc_data matches; arb2ic_tag = 0; outstanding_cnt goes 0 → 1 → 0.
- Contention and starvation: IC and DC request every cycle, memory always accepts. Required: DC wins while starve_cnt < 4; the I-cache wins the cycle after 4 consecutive denials; starve_cnt then returns to 0.
- Busy memory: DC LOAD while mem2proc_response = 0 for 3 cycles, then 5. Required: arb2dc_response is 0,0,0,5; no entry allocated before the 4th cycle; outstanding_cnt ends at 1.
- Interleaved returns: IC load tagged 2, DC load tagged 7; memory returns 7 then 2. Required: DC receives tag 7, then IC receives tag 2, with no crossover of data.
- Same-cycle reuse and stores: in one cycle, tag 4 (owned by IC) returns and DC is accepted with tag 4. Required: IC receives the return, entry 4's owner becomes DC, and outstanding_cnt is unchanged. Separately, a DC STORE accepted with tag 6 leaves outstanding_cnt unchanged.
- Errors and reset: mem2proc_tag = 9 with no owner → tag_error = 1 from the next cycle. Asserting reset mid-flight with 2 loads outstanding → outstanding_cnt = 0 and tag_error = 0 immediately (asynchronous), and all outputs 0 while reset is held.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single off-chip memory port between the I-cache and D-cache miss
// paths. One request is placed on the bus per cycle. The D-cache wins by
// default, and a starvation counter forces an I-cache grant after STARVE_LIMIT
// consecutive cycles in which the I-cache asked and was not accepted. A
// 15-entry tag table remembers which requester owns each outstanding load tag,
// so returned data can be steered back to that requester.
//
// Ports:
//   clock, reset          - clock (posedge) and asynchronous active-low reset
//   ic2arb_command/addr   - I-cache request (NONE or LOAD)
//   arb2ic_response       - accept tag for the I-cache (0 = retry)
//   arb2ic_data/tag       - returned line and tag for the I-cache (tag 0 = none)
//   dc2arb_command/addr/data/size - D-cache request (NONE, LOAD or STORE)
//   arb2dc_response       - accept tag for the D-cache (0 = retry)
//   arb2dc_data/tag       - returned data and tag for the D-cache
//   proc2mem_*            - shared memory bus request
//   mem2proc_response     - memory accept tag (0 = busy)
//   mem2proc_data/tag     - memory return (tag 0 = none)
//   outstanding_cnt       - number of valid tag-table entries
//   tag_error             - sticky flag: unowned return or double allocation
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      ic2arb_command,
    input  logic [XLEN-1:0] ic2arb_addr,
    output logic [3:0]      arb2ic_response,
    output logic [63:0]     arb2ic_data,
    output logic [3:0]      arb2ic_tag,
    input  logic [1:0]      dc2arb_command,
    input  logic [XLEN-1:0] dc2arb_addr,
    input  logic [63:0]     dc2arb_data,
    input  logic [1:0]      dc2arb_size,
    output logic [3:0]      arb2dc_response,
    output logic [63:0]     arb2dc_data,
    output logic [3:0]      arb2dc_tag,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    output logic [1:0]      proc2mem_size,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
    output logic [4:0]      outstanding_cnt,
    output logic            tag_error
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0]    CMD_NONE    = 2'd0;
    localparam logic [1:0]    CMD_LOAD    = 2'd1;
    localparam logic [1:0]    SIZE_DOUBLE = 2'd3;
    localparam logic [SW-1:0] STARVE_MAX  = SW'(STARVE_LIMIT);

    // Number of valid table entries; bit 0 never holds a live tag.
    function automatic logic [4:0] count_valid(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 1; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    // Tag table state (index = tag, entry 0 unused), counters and flags
    logic [15:0]   valid_r;
    logic [15:0]   owner_r;     // 1 = D-cache, 0 = I-cache
    logic [SW-1:0] starve_cnt_r;
    logic [4:0]    outstanding_r;
    logic          tag_error_r;

    logic [15:0]   valid_s;
    logic [15:0]   owner_s;
    logic [SW-1:0] starve_cnt_s;
    logic          tag_error_s;

    logic            ic_req_s;
    logic            dc_req_s;
    logic            force_ic_s;
    logic            grant_ic_s;
    logic            grant_dc_s;
    logic [1:0]      bus_cmd_s;
    logic [XLEN-1:0] bus_addr_s;
    logic [63:0]     bus_data_s;
    logic [1:0]      bus_size_s;
    logic            accept_s;
    logic            alloc_s;
    logic            ret_hit_s;
    logic            ret_miss_s;
    logic            ret_owner_s;
    logic            realloc_err_s;

    // Grant selection: D-cache by default, I-cache when alone or starved
    always_comb begin
        ic_req_s   = (ic2arb_command != CMD_NONE);
        dc_req_s   = (dc2arb_command != CMD_NONE);
        force_ic_s = (starve_cnt_r == STARVE_MAX);
        grant_ic_s = ic_req_s && (!dc_req_s || force_ic_s);
        grant_dc_s = dc_req_s && !grant_ic_s;
    end

    // Bus request mux; the I-cache always moves whole lines with no store data
    always_comb begin
        bus_cmd_s  = CMD_NONE;
        bus_addr_s = {XLEN{1'b0}};
        bus_data_s = 64'd0;
        bus_size_s = 2'd0;
        if (grant_ic_s) begin
            bus_cmd_s  = ic2arb_command;
            bus_addr_s = ic2arb_addr;
            bus_data_s = 64'd0;
            bus_size_s = SIZE_DOUBLE;
        end else if (grant_dc_s) begin
            bus_cmd_s  = dc2arb_command;
            bus_addr_s = dc2arb_addr;
            bus_data_s = dc2arb_data;
            bus_size_s = dc2arb_size;
        end else begin
            bus_cmd_s  = CMD_NONE;
            bus_addr_s = {XLEN{1'b0}};
            bus_data_s = 64'd0;
            bus_size_s = 2'd0;
        end
    end

    // Accept and return classification against the current table
    always_comb begin
        accept_s    = (mem2proc_response != 4'd0);
        alloc_s     = accept_s && (bus_cmd_s == CMD_LOAD);
        ret_hit_s   = (mem2proc_tag != 4'd0) && valid_r[mem2proc_tag];
        ret_miss_s  = (mem2proc_tag != 4'd0) && !valid_r[mem2proc_tag];
        ret_owner_s = owner_r[mem2proc_tag];
        // Reusing a tag that is being returned this same cycle is legitimate.
        realloc_err_s = alloc_s && valid_r[mem2proc_response] &&
                        !(ret_hit_s && (mem2proc_tag == mem2proc_response));
    end

    // Next table contents; allocation is applied last so it wins a same-tag clear
    always_comb begin
        valid_s = valid_r;
        owner_s = owner_r;
        if (ret_hit_s) begin
            valid_s[mem2proc_tag] = 1'b0;
        end else begin
            valid_s = valid_s;
        end
        if (alloc_s) begin
            valid_s[mem2proc_response] = 1'b1;
            owner_s[mem2proc_response] = grant_dc_s;
        end else begin
            owner_s = owner_s;
        end
        tag_error_s = tag_error_r || ret_miss_s || realloc_err_s;
    end

    // Starvation counter: clears on I-cache idle or accept, saturates otherwise
    always_comb begin
        if (!ic_req_s) begin
            starve_cnt_s = {SW{1'b0}};
        end else if (grant_ic_s && accept_s) begin
            starve_cnt_s = {SW{1'b0}};
        end else if (starve_cnt_r != STARVE_MAX) begin
            starve_cnt_s = starve_cnt_r + SW'(1);
        end else begin
            starve_cnt_s = starve_cnt_r;
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r       <= 16'd0;
            owner_r       <= 16'd0;
            starve_cnt_r  <= {SW{1'b0}};
            outstanding_r <= 5'd0;
            tag_error_r   <= 1'b0;
        end else begin
            valid_r       <= valid_s;
            owner_r       <= owner_s;
            starve_cnt_r  <= starve_cnt_s;
            outstanding_r <= count_valid(valid_s);
            tag_error_r   <= tag_error_s;
        end
    end

    // Output drive; everything is held at zero while reset is asserted
    always_comb begin
        if (!reset) begin
            proc2mem_command = CMD_NONE;
            proc2mem_addr    = {XLEN{1'b0}};
            proc2mem_data    = 64'd0;
            proc2mem_size    = 2'd0;
            arb2ic_response  = 4'd0;
            arb2dc_response  = 4'd0;
            arb2ic_tag       = 4'd0;
            arb2ic_data      = 64'd0;
            arb2dc_tag       = 4'd0;
            arb2dc_data      = 64'd0;
        end else begin
            proc2mem_command = bus_cmd_s;
            proc2mem_addr    = bus_addr_s;
            proc2mem_data    = bus_data_s;
            proc2mem_size    = bus_size_s;
            arb2ic_response  = grant_ic_s ? mem2proc_response : 4'd0;
            arb2dc_response  = grant_dc_s ? mem2proc_response : 4'd0;
            arb2ic_tag       = (ret_hit_s && !ret_owner_s) ? mem2proc_tag  : 4'd0;
            arb2ic_data      = (ret_hit_s && !ret_owner_s) ? mem2proc_data : 64'd0;
            arb2dc_tag       = (ret_hit_s &&  ret_owner_s) ? mem2proc_tag  : 4'd0;
            arb2dc_data      = (ret_hit_s &&  ret_owner_s) ? mem2proc_data : 64'd0;
        end
    end

    assign outstanding_cnt = outstanding_r;
    assign tag_error       = tag_error_r;

endmodule
